// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Requester handshake and RAM-side bus of the three-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );

  // Requesters plus RAM side
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Serialises three requesters onto one single-port synchronous RAM.
//            Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration
//            (default: fixed priority port0 > port1 > port2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  wire logic          clock,
  input  wire logic          resetn,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          rvalid_q, rvalid_d;
  logic [2:0]          gnt_w;
  logic                mem_we_w;
  logic [1:0]          winner_w;
  logic                found_w;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Search starts one past the last winner.
  always_comb begin
    found_w  = 1'b0;
    winner_w = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      if (!found_w && bus.req[(int'(rr_ptr_q) + k) % 3]) begin
        found_w  = 1'b1;
        winner_w = 2'((int'(rr_ptr_q) + k) % 3);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && found_w) begin
      rr_ptr_d = winner_w;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_ptr_q <= 2'd2;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    found_w  = |bus.req;
    winner_w = 2'd0;
    if (bus.req[0]) begin
      winner_w = 2'd0;
    end else if (bus.req[1]) begin
      winner_w = 2'd1;
    end else if (bus.req[2]) begin
      winner_w = 2'd2;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_cnt_d   = lat_cnt_q;
    rdata_d     = rdata_q;
    rvalid_d    = 3'b000;
    gnt_w       = 3'b000;
    mem_we_w    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_w) begin
          owner_d = winner_w;
          state_d = S_ACCESS;
          for (int p = 0; p < 3; p++) begin
            if (winner_w == 2'(p)) begin
              gnt_w[p]    = 1'b1;
              we_d        = bus.we[p];
              mem_addr_d  = bus.addr[p*ADDR_W +: ADDR_W];
              mem_wdata_d = bus.wdata[p*DATA_W +: DATA_W];
            end
          end
        end
      end
      S_ACCESS: begin
        mem_we_w = we_q;
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          lat_cnt_d = 3'(READ_LATENCY - 1);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          rdata_d           = bus.mem_rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'd0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_cnt_q   <= 3'd0;
      rdata_q     <= '0;
      rvalid_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_cnt_q   <= lat_cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Grant and write strobe are combinational, so gate them off during reset.
  assign bus.gnt       = resetn ? gnt_w : 3'b000;
  assign bus.mem_we    = resetn & mem_we_w;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire
